// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory request path.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int MAX_OUTSTANDING_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCEPTED,
    ST_CANCEL
  } req_state_e;

endpackage

// File: rtl/store_align.sv
// Store lane alignment: byte enables, lane-replicated write data and misalignment flag.
module store_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_ale
);

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_data;
    o_ale   = 1'b0;
    case (i_size)
      SZ_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      SZ_H: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_data[15:0]}};
        o_ale   = i_addr_lo[0];
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_data;
        o_ale   = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/data_req_unit.sv
// EXE-stage load/store issuer on the data_sram req/addr_ok/data_ok interface,
// with outstanding tracking and discard of responses for flushed requests.
module data_req_unit
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_valid,
  input  logic        es_mem_re,
  input  logic        es_mem_we,
  input  logic [1:0]  es_mem_size,
  input  logic [31:0] es_vaddr,
  input  logic [31:0] es_store_data,
  input  logic        es_flush,
  input  logic        ms_allowin,
  output logic        es_mem_ready_go,
  output logic        es_ale,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        ms_data_ok
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  req_state_e    r_state;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [3:0]    r_wstrb;

  logic        w_mem_op;
  logic        w_misalign;
  logic        w_issue;
  logic        w_req;
  logic        w_hs;
  logic        w_live;
  logic        w_discard_inc;
  logic        w_discard_dec;
  logic [1:0]  w_size;
  logic [3:0]  w_wstrb_al;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_size = (es_mem_size == 2'd3) ? SZ_W : es_mem_size;

  store_align u_store_align (
    .i_size    (w_size),
    .i_addr_lo (es_vaddr[1:0]),
    .i_data    (es_store_data),
    .o_wstrb   (w_wstrb_al),
    .o_wdata   (w_wdata),
    .o_ale     (w_misalign)
  );

  assign w_wstrb  = es_mem_we ? w_wstrb_al : '0;
  assign w_mem_op = es_valid & (es_mem_re | es_mem_we);
  assign es_ale   = w_mem_op & w_misalign;
  assign w_issue  = w_mem_op & ~w_misalign & ~es_flush & ms_allowin
                  & (r_outstanding < MAX_CNT);

  // Once raised, a request stays up until addr_ok, even across a flush.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      ST_IDLE:            w_req = w_issue;
      ST_REQ, ST_CANCEL:  w_req = 1'b1;
      default:            w_req = 1'b0;
    endcase
    if (reset) w_req = 1'b0;
  end

  assign w_hs   = w_req & data_sram_addr_ok;
  assign w_live = (r_state == ST_IDLE);

  assign data_sram_req   = w_req;
  assign data_sram_wr    = w_live ? es_mem_we : r_wr;
  assign data_sram_size  = w_live ? w_size    : r_size;
  assign data_sram_wstrb = w_live ? w_wstrb   : r_wstrb;
  assign data_sram_addr  = w_live ? es_vaddr  : r_addr;
  assign data_sram_wdata = w_live ? w_wdata   : r_wdata;

  // A flush that coincides with addr_ok in REQ still leaves an accepted,
  // now-orphaned request, so it is counted for discard like CANCEL.
  assign w_discard_inc = ((r_state == ST_CANCEL) & w_hs)
                       | ((r_state == ST_REQ) & w_hs & es_flush)
                       | ((r_state == ST_ACCEPTED) & es_flush);
  assign w_discard_dec = data_sram_data_ok & (r_discard_cnt != '0);

  assign ms_data_ok = ~reset & data_sram_data_ok & (r_discard_cnt == '0);

  assign es_mem_ready_go = ~reset & (r_state != ST_CANCEL)
                         & (~w_mem_op | es_ale
                            | (w_hs & (r_state == ST_IDLE || r_state == ST_REQ))
                            | (r_state == ST_ACCEPTED));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wr          <= 1'b0;
      r_size        <= '0;
      r_wstrb       <= '0;
    end else begin
      case ({w_hs, data_sram_data_ok})
        2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase

      case ({w_discard_inc, w_discard_dec})
        2'b10:   r_discard_cnt <= r_discard_cnt + CNT_ONE;
        2'b01:   r_discard_cnt <= r_discard_cnt - CNT_ONE;
        default: r_discard_cnt <= r_discard_cnt;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (w_req && !data_sram_addr_ok) begin
            r_state <= ST_REQ;
            r_addr  <= es_vaddr;
            r_wr    <= es_mem_we;
            r_size  <= w_size;
            r_wstrb <= w_wstrb;
            r_wdata <= w_wdata;
          end else if (w_hs && !ms_allowin) begin
            r_state <= ST_ACCEPTED;
          end
        end
        ST_REQ: begin
          if (data_sram_addr_ok)
            r_state <= (es_flush || ms_allowin) ? ST_IDLE : ST_ACCEPTED;
          else if (es_flush)
            r_state <= ST_CANCEL;
        end
        ST_CANCEL: begin
          if (data_sram_addr_ok) r_state <= ST_IDLE;
        end
        ST_ACCEPTED: begin
          if (es_flush || ms_allowin) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(data_sram_data_ok && r_outstanding == '0));

endmodule

// File: tb/tb_data_req_unit.sv
// Directed bench for data_req_unit: single-cycle issue table plus multi-cycle sequences.
module tb_data_req_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_valid, es_mem_re, es_mem_we, es_flush, ms_allowin;
  logic [1:0]  es_mem_size;
  logic [31:0] es_vaddr, es_store_data;
  logic        es_mem_ready_go, es_ale;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok, ms_data_ok;

  always #5 clk = ~clk;

  data_req_unit #(.MAX_OUTSTANDING(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_valid          (es_valid),
    .es_mem_re         (es_mem_re),
    .es_mem_we         (es_mem_we),
    .es_mem_size       (es_mem_size),
    .es_vaddr          (es_vaddr),
    .es_store_data     (es_store_data),
    .es_flush          (es_flush),
    .ms_allowin        (ms_allowin),
    .es_mem_ready_go   (es_mem_ready_go),
    .es_ale            (es_ale),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .ms_data_ok        (ms_data_ok)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid, re, we;
    logic [1:0]  size;
    logic [31:0] addr, sdata;
    logic        flush, allowin;
    logic        e_req, e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic        e_ale, e_rdy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic valid, re, we, input logic [1:0] size,
                              input logic [31:0] addr, sdata, input logic flush, allowin,
                              input logic e_req, e_wr, input logic [1:0] e_size,
                              input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                              input logic e_ale, e_rdy);
    vec_t v;
    v.valid = valid; v.re = re; v.we = we; v.size = size; v.addr = addr;
    v.sdata = sdata; v.flush = flush; v.allowin = allowin;
    v.e_req = e_req; v.e_wr = e_wr; v.e_size = e_size; v.e_wstrb = e_wstrb;
    v.e_wdata = e_wdata; v.e_ale = e_ale; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    es_valid = 0; es_mem_re = 0; es_mem_we = 0; es_mem_size = 2'd0;
    es_vaddr = '0; es_store_data = '0; es_flush = 0; ms_allowin = 1;
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
  endtask

  task automatic load(input logic [31:0] addr);
    es_valid = 1; es_mem_re = 1; es_mem_we = 0; es_mem_size = 2'd2;
    es_vaddr = addr; es_store_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    reset = 1;
    // Outputs stay quiet during reset even with live stimulus.
    repeat (2) begin
      @(negedge clk);
      load(32'h0000_0100); data_sram_addr_ok = 1; data_sram_data_ok = 1;
      #1;
      chk("rst_req", {31'd0, data_sram_req}, 0);
      chk("rst_ms_data_ok", {31'd0, ms_data_ok}, 0);
      chk("rst_ready_go", {31'd0, es_mem_ready_go}, 0);
    end
    @(negedge clk); idle_in(); reset = 0;

    //           v  re we sz    addr          sdata         fl al  req wr sz    wstrb    wdata         ale rdy
    vecs[0]  = mk(1, 0, 1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, 0, 1, 1, 1, 2'd2, 4'b1111, 32'hDEAD_BEEF, 0, 1);
    vecs[1]  = mk(1, 0, 1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 0, 1, 1, 1, 2'd0, 4'b1000, 32'hA5A5_A5A5, 0, 1);
    vecs[2]  = mk(1, 1, 0, 2'd1, 32'h0000_1001, 32'h1234_5678, 0, 1, 0, 0, 2'd1, 4'b0000, 32'h5678_5678, 1, 1);
    vecs[3]  = mk(1, 0, 1, 2'd1, 32'h0000_1002, 32'h0000_BEEF, 0, 1, 1, 1, 2'd1, 4'b1100, 32'hBEEF_BEEF, 0, 1);
    vecs[4]  = mk(1, 0, 1, 2'd0, 32'h0000_1001, 32'h1122_3344, 0, 1, 1, 1, 2'd0, 4'b0010, 32'h4444_4444, 0, 1);
    vecs[5]  = mk(1, 1, 0, 2'd2, 32'h0000_2000, 32'h0000_0000, 0, 1, 1, 0, 2'd2, 4'b0000, 32'h0000_0000, 0, 1);
    vecs[6]  = mk(1, 0, 1, 2'd2, 32'h0000_1002, 32'h0000_0000, 0, 1, 0, 1, 2'd2, 4'b1111, 32'h0000_0000, 1, 1);
    vecs[7]  = mk(1, 0, 0, 2'd2, 32'h0000_0001, 32'h0000_0000, 0, 1, 0, 0, 2'd2, 4'b0000, 32'h0000_0000, 0, 1);
    vecs[8]  = mk(0, 1, 0, 2'd2, 32'h0000_0003, 32'h0000_0000, 0, 1, 0, 0, 2'd2, 4'b0000, 32'h0000_0000, 0, 1);
    vecs[9]  = mk(1, 1, 0, 2'd2, 32'h0000_2004, 32'h0000_0000, 1, 1, 0, 0, 2'd2, 4'b0000, 32'h0000_0000, 0, 0);
    vecs[10] = mk(1, 1, 0, 2'd2, 32'h0000_2008, 32'h0000_0000, 0, 0, 0, 0, 2'd2, 4'b0000, 32'h0000_0000, 0, 0);
    vecs[11] = mk(1, 0, 1, 2'd3, 32'h0000_3000, 32'hCAFE_F00D, 0, 1, 1, 1, 2'd2, 4'b1111, 32'hCAFE_F00D, 0, 1);
    vecs[12] = mk(1, 1, 0, 2'd3, 32'h0000_3001, 32'h0000_0000, 0, 1, 0, 0, 2'd2, 4'b0000, 32'h0000_0000, 1, 1);
    vecs[13] = mk(1, 0, 1, 2'd1, 32'h0000_1001, 32'h0000_1234, 0, 1, 0, 1, 2'd1, 4'b0011, 32'h1234_1234, 1, 1);
    vecs[14] = mk(1, 1, 0, 2'd0, 32'h0000_1003, 32'h0000_0000, 0, 1, 1, 0, 2'd0, 4'b0000, 32'h0000_0000, 0, 1);
    vecs[15] = mk(1, 0, 1, 2'd1, 32'h0000_1003, 32'h0000_0000, 1, 1, 0, 1, 2'd1, 4'b1000, 32'h0000_0000, 1, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      es_valid = vecs[i].valid; es_mem_re = vecs[i].re; es_mem_we = vecs[i].we;
      es_mem_size = vecs[i].size; es_vaddr = vecs[i].addr; es_store_data = vecs[i].sdata;
      es_flush = vecs[i].flush; ms_allowin = vecs[i].allowin;
      data_sram_addr_ok = 1; data_sram_data_ok = 0;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, data_sram_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_ale", i), {31'd0, es_ale}, {31'd0, vecs[i].e_ale});
      chk($sformatf("v%0d_rdy", i), {31'd0, es_mem_ready_go}, {31'd0, vecs[i].e_rdy});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_wr", i), {31'd0, data_sram_wr}, {31'd0, vecs[i].e_wr});
        chk($sformatf("v%0d_size", i), {30'd0, data_sram_size}, {30'd0, vecs[i].e_size});
        chk($sformatf("v%0d_wstrb", i), {28'd0, data_sram_wstrb}, {28'd0, vecs[i].e_wstrb});
        chk($sformatf("v%0d_wdata", i), data_sram_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_addr", i), data_sram_addr, vecs[i].addr);
      end
      @(negedge clk);
      idle_in(); data_sram_data_ok = vecs[i].e_req;
      #1;
      chk($sformatf("v%0d_ms_data_ok", i), {31'd0, ms_data_ok}, {31'd0, vecs[i].e_req});
    end

    // addr_ok held low for 3 cycles; fields must stay latched even if EXE inputs move.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      load(c == 0 ? 32'h0000_4000 : 32'h0000_5000);
      data_sram_addr_ok = (c == 3);
      #1;
      chk($sformatf("stall%0d_req", c), {31'd0, data_sram_req}, 1);
      chk($sformatf("stall%0d_addr", c), data_sram_addr, 32'h0000_4000);
      chk($sformatf("stall%0d_wr", c), {31'd0, data_sram_wr}, 0);
      chk($sformatf("stall%0d_rdy", c), {31'd0, es_mem_ready_go}, {31'd0, c == 3});
    end
    @(negedge clk); idle_in(); data_sram_data_ok = 1; #1;
    chk("stall_ms_data_ok", {31'd0, ms_data_ok}, 1);

    // Flush while in REQ: request held to handshake, its response dropped.
    @(negedge clk); idle_in(); load(32'h0000_6000); #1;
    chk("fl0_req", {31'd0, data_sram_req}, 1);
    @(negedge clk); idle_in(); es_flush = 1; #1;
    chk("fl1_req", {31'd0, data_sram_req}, 1);
    chk("fl1_addr", data_sram_addr, 32'h0000_6000);
    @(negedge clk); idle_in(); #1;
    chk("fl2_req", {31'd0, data_sram_req}, 1);
    chk("fl2_rdy", {31'd0, es_mem_ready_go}, 0);
    @(negedge clk); idle_in(); data_sram_addr_ok = 1; #1;
    chk("fl3_req", {31'd0, data_sram_req}, 1);
    chk("fl3_addr", data_sram_addr, 32'h0000_6000);
    chk("fl3_rdy", {31'd0, es_mem_ready_go}, 0);
    @(negedge clk); idle_in(); data_sram_data_ok = 1; #1;
    chk("fl4_ms_data_ok", {31'd0, ms_data_ok}, 0);
    @(negedge clk); idle_in(); load(32'h0000_6100); data_sram_addr_ok = 1; #1;
    chk("fl5_req", {31'd0, data_sram_req}, 1);
    @(negedge clk); idle_in(); data_sram_data_ok = 1; #1;
    chk("fl6_ms_data_ok", {31'd0, ms_data_ok}, 1);

    // Outstanding limit, then addr_ok and data_ok in the same cycle.
    @(negedge clk); idle_in(); load(32'h0000_8000); data_sram_addr_ok = 1; #1;
    chk("ob0_req", {31'd0, data_sram_req}, 1);
    @(negedge clk); idle_in(); load(32'h0000_8004); data_sram_addr_ok = 1; #1;
    chk("ob1_req", {31'd0, data_sram_req}, 1);
    @(negedge clk); idle_in(); load(32'h0000_8008); data_sram_addr_ok = 1; #1;
    chk("ob2_req", {31'd0, data_sram_req}, 0);
    chk("ob2_rdy", {31'd0, es_mem_ready_go}, 0);
    @(negedge clk); idle_in(); load(32'h0000_8008); data_sram_data_ok = 1; #1;
    chk("ob3_req", {31'd0, data_sram_req}, 0);
    chk("ob3_ms_data_ok", {31'd0, ms_data_ok}, 1);
    @(negedge clk); idle_in(); load(32'h0000_8008); data_sram_addr_ok = 1; data_sram_data_ok = 1; #1;
    chk("ob4_req", {31'd0, data_sram_req}, 1);
    chk("ob4_ms_data_ok", {31'd0, ms_data_ok}, 1);
    @(negedge clk); idle_in(); load(32'h0000_800C); data_sram_addr_ok = 1; #1;
    chk("ob5_req", {31'd0, data_sram_req}, 1);
    @(negedge clk); idle_in(); load(32'h0000_8010); data_sram_addr_ok = 1; #1;
    chk("ob6_req", {31'd0, data_sram_req}, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle_in(); data_sram_data_ok = 1; #1;
      chk($sformatf("ob_drain%0d_ms_data_ok", k), {31'd0, ms_data_ok}, 1);
    end

    // Accepted while MEM stalls, then flushed: its response must be dropped.
    @(negedge clk); idle_in(); load(32'h0000_7000); #1;
    chk("acc0_req", {31'd0, data_sram_req}, 1);
    @(negedge clk); idle_in(); load(32'h0000_7000); ms_allowin = 0; data_sram_addr_ok = 1; #1;
    chk("acc1_rdy", {31'd0, es_mem_ready_go}, 1);
    @(negedge clk); idle_in(); load(32'h0000_7000); ms_allowin = 0; #1;
    chk("acc2_req", {31'd0, data_sram_req}, 0);
    chk("acc2_rdy", {31'd0, es_mem_ready_go}, 1);
    @(negedge clk); idle_in(); es_flush = 1; #1;
    chk("acc3_req", {31'd0, data_sram_req}, 0);
    @(negedge clk); idle_in(); data_sram_data_ok = 1; #1;
    chk("acc4_ms_data_ok", {31'd0, ms_data_ok}, 0);
    @(negedge clk); idle_in(); load(32'h0000_7100); data_sram_addr_ok = 1; #1;
    chk("acc5_req", {31'd0, data_sram_req}, 1);
    @(negedge clk); idle_in(); data_sram_data_ok = 1; #1;
    chk("acc6_ms_data_ok", {31'd0, ms_data_ok}, 1);

    @(negedge clk); idle_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
